// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the multiplexed seven-segment scan controller.
//   - GLY_*  : 5-bit glyph codes accepted on glyph_in
//   - SEG_*  : 7-bit segment patterns, bit order {a,b,c,d,e,f,g} (a = MSB)
// Codes 15 and 17..31 are blank. Code 16 lights segment g only.
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam logic [4:0] GLY_0    = 5'd0;
   localparam logic [4:0] GLY_1    = 5'd1;
   localparam logic [4:0] GLY_2    = 5'd2;
   localparam logic [4:0] GLY_3    = 5'd3;
   localparam logic [4:0] GLY_4    = 5'd4;
   localparam logic [4:0] GLY_5    = 5'd5;
   localparam logic [4:0] GLY_6    = 5'd6;
   localparam logic [4:0] GLY_7    = 5'd7;
   localparam logic [4:0] GLY_8    = 5'd8;
   localparam logic [4:0] GLY_9    = 5'd9;
   localparam logic [4:0] GLY_S    = 5'd10;
   localparam logic [4:0] GLY_E    = 5'd11;
   localparam logic [4:0] GLY_L    = 5'd12;
   localparam logic [4:0] GLY_C    = 5'd13;
   localparam logic [4:0] GLY_T    = 5'd14;
   localparam logic [4:0] GLY_OFF  = 5'd15;
   localparam logic [4:0] GLY_DASH = 5'd16;

   //                                    abcdefg
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_S     = 7'b1011011;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_L     = 7'b0001110;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_T     = 7'b0001111;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_ctrl_glyph_dec.sv
// -----------------------------------------------------------------------------
// seg_glyph_dec
// Purely combinational glyph-code to segment-pattern lookup.
// Ports:
//   i_glyph [4:0] : glyph code (see seg_pkg GLY_*)
//   o_seg   [6:0] : segments {a..g}, active-high
// -----------------------------------------------------------------------------
module seg_glyph_dec
   import seg_pkg::*;
(
   input  logic [4:0] i_glyph,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_glyph)
         GLY_0:    o_seg = SEG_0;
         GLY_1:    o_seg = SEG_1;
         GLY_2:    o_seg = SEG_2;
         GLY_3:    o_seg = SEG_3;
         GLY_4:    o_seg = SEG_4;
         GLY_5:    o_seg = SEG_5;
         GLY_6:    o_seg = SEG_6;
         GLY_7:    o_seg = SEG_7;
         GLY_8:    o_seg = SEG_8;
         GLY_9:    o_seg = SEG_9;
         GLY_S:    o_seg = SEG_S;
         GLY_E:    o_seg = SEG_E;
         GLY_L:    o_seg = SEG_L;
         GLY_C:    o_seg = SEG_C;
         GLY_T:    o_seg = SEG_T;
         GLY_DASH: o_seg = SEG_DASH;
         // GLY_OFF and the unused codes 17..31 stay blank
         default:  o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed seven-segment scan controller. N_BANKS segment banks share
// one one-hot digit-select bus. Each digit slot lasts SCAN_DIV clocks, the
// first DEAD_CYC of which are blanked to avoid ghosting. New display content
// is taken only at the frame boundary (last cycle of the last digit), so a
// frame is never torn.
//
// Optional feature macro: SEG_BLINK_EN
//   defined   : per-digit blink; phase toggles every BLINK_DIV frames and
//               blinking digits go dark while the phase is 0.
//   undefined : blink_in is ignored; no blink state is built.
//
// Ports:
//   clk_sys     in   system clock
//   rst         in   asynchronous active-high reset
//   glyph_in    in   N_BANKS*N_DIGITS*5, bank b digit d at [(b*N_DIGITS+d)*5 +: 5]
//   dp_in       in   N_BANKS*N_DIGITS decimal points, same index order
//   blink_in    in   N_BANKS*N_DIGITS blink enables, same index order
//   upd_valid   in   new content offered (held until upd_ready)
//   upd_ready   out  frame-boundary accept strobe
//   seg         out  N_BANKS*7 segments {a..g}, bank b at [b*7 +: 7]
//   dp          out  N_BANKS decimal points
//   mux         out  N_DIGITS one-hot digit select, zero while blanking
//   frame_tick  out  one-cycle pulse on the frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int N_BANKS   = 2,
   parameter int SCAN_DIV  = 50000,
   parameter int DEAD_CYC  = 16,
   parameter int BLINK_DIV = 64
)(
   input  logic                            clk_sys,
   input  logic                            rst,
   input  logic [N_BANKS*N_DIGITS*5-1:0]   glyph_in,
   input  logic [N_BANKS*N_DIGITS-1:0]     dp_in,
   input  logic [N_BANKS*N_DIGITS-1:0]     blink_in,
   input  logic                            upd_valid,
   output logic                            upd_ready,
   output logic [N_BANKS*7-1:0]            seg,
   output logic [N_BANKS-1:0]              dp,
   output logic [N_DIGITS-1:0]             mux,
   output logic                            frame_tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [CW-1:0]       CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]       CNT_DEAD = CW'(DEAD_CYC);
   localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] SEL_D0   = {{(N_DIGITS-1){1'b0}}, 1'b1};

   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic [N_DIGITS-1:0] r_mux;
   logic [CW-1:0]       w_cnt_next;
   logic [IW-1:0]       w_idx_next;
   logic [N_DIGITS-1:0] w_mux_next;
   logic                w_boundary;
   logic                w_lit_slot;
   logic                w_load;

   // Shadow copy of the displayed content, one element per bank/digit
   logic [4:0] w_sh_glyph [N_BANKS][N_DIGITS];
   logic       w_sh_dp    [N_BANKS][N_DIGITS];

   // ---------------------------------------------------------------------
   // Scan timing. Output registers are loaded from the *next* counter
   // state so seg/dp/mux line up exactly with r_cnt/r_idx.
   // ---------------------------------------------------------------------
   always_comb begin
      w_boundary = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
      w_cnt_next = r_cnt + 1'b1;
      w_idx_next = r_idx;
      if (r_cnt == CNT_LAST) begin
         w_cnt_next = '0;
         w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      w_lit_slot = (w_cnt_next >= CNT_DEAD);
      w_mux_next = w_lit_slot ? (SEL_D0 << w_idx_next) : '0;
      w_load     = upd_valid && w_boundary;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_mux <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         r_idx <= w_idx_next;
         r_mux <= w_mux_next;
      end
   end

   assign mux        = r_mux;
   assign upd_ready  = w_boundary;
   assign frame_tick = w_boundary;

   // ---------------------------------------------------------------------
   // Blink phase: starts lit, toggles after every BLINK_DIV boundaries
   // ---------------------------------------------------------------------
`ifdef SEG_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic          r_blink_phase;
   logic [BW-1:0] r_blink_cnt;
   logic          w_sh_blink [N_BANKS][N_DIGITS];

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_blink_phase <= 1'b1;
         r_blink_cnt   <= '0;
      end else if (w_boundary) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic w_unused_blink;
   assign w_unused_blink = ^blink_in;
`endif

   // ---------------------------------------------------------------------
   // Shadow registers, loaded only on an accepted handshake
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank_sh
         for (genvar gd = 0; gd < N_DIGITS; gd++) begin : g_digit_sh
            localparam int FLAT = gi * N_DIGITS + gd;
            logic [4:0] r_glyph;
            logic       r_dp;

            always_ff @(posedge clk_sys or posedge rst) begin
               if (rst) begin
                  r_glyph <= GLY_OFF;
                  r_dp    <= 1'b0;
               end else if (w_load) begin
                  r_glyph <= glyph_in[FLAT*5 +: 5];
                  r_dp    <= dp_in[FLAT];
               end
            end

            assign w_sh_glyph[gi][gd] = r_glyph;
            assign w_sh_dp[gi][gd]    = r_dp;

`ifdef SEG_BLINK_EN
            logic r_blink;
            always_ff @(posedge clk_sys or posedge rst) begin
               if (rst) begin
                  r_blink <= 1'b0;
               end else if (w_load) begin
                  r_blink <= blink_in[FLAT];
               end
            end
            assign w_sh_blink[gi][gd] = r_blink;
`endif
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Per-bank decode and output registers
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank_out
         logic [4:0] w_cur_glyph;
         logic [6:0] w_dec;
         logic       w_show;
         logic [6:0] r_seg;
         logic       r_dp;

         assign w_cur_glyph = w_sh_glyph[gi][w_idx_next];

         seg_glyph_dec u_dec (
            .i_glyph (w_cur_glyph),
            .o_seg   (w_dec)
         );

`ifdef SEG_BLINK_EN
         // Blinking digits stay scanned (mux still selects them) but dark
         assign w_show = w_lit_slot && (r_blink_phase || !w_sh_blink[gi][w_idx_next]);
`else
         assign w_show = w_lit_slot;
`endif

         always_ff @(posedge clk_sys or posedge rst) begin
            if (rst) begin
               r_seg <= '0;
               r_dp  <= 1'b0;
            end else begin
               r_seg <= w_show ? w_dec : 7'b0;
               r_dp  <= w_show && w_sh_dp[gi][w_idx_next];
            end
         end

         assign seg[gi*7 +: 7] = r_seg;
         assign dp[gi]         = r_dp;
      end
   endgenerate

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int NB = 2;
   localparam int SD = 8;
   localparam int DC = 2;
   localparam int BD = 2;
   localparam int FR = SD * ND;

   logic                 clk_sys = 1'b0;
   logic                 rst     = 1'b1;
   logic [NB*ND*5-1:0]   glyph_in = '0;
   logic [NB*ND-1:0]     dp_in    = '0;
   logic [NB*ND-1:0]     blink_in = '0;
   logic                 upd_valid = 1'b0;
   logic                 upd_ready;
   logic [NB*7-1:0]      seg;
   logic [NB-1:0]        dp;
   logic [ND-1:0]        mux;
   logic                 frame_tick;

   seg_scan_ctrl #(
      .N_DIGITS  (ND),
      .N_BANKS   (NB),
      .SCAN_DIV  (SD),
      .DEAD_CYC  (DC),
      .BLINK_DIV (BD)
   ) dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .glyph_in   (glyph_in),
      .dp_in      (dp_in),
      .blink_in   (blink_in),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .seg        (seg),
      .dp         (dp),
      .mux        (mux),
      .frame_tick (frame_tick)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] seg_tab [32];
   int         t;
   int         m_glyph [NB][ND];
   bit         m_dp    [NB][ND];
   bit         m_blink [NB][ND];
   bit         chk_en = 1'b0;

   function automatic bit is_bnd(input int tt);
      return ((tt % SD) == SD - 1) && (((tt / SD) % ND) == ND - 1);
   endfunction

   // Cycle t = number of clock edges since reset release
   always @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         t <= 0;
         for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++) begin
               m_glyph[b][d] <= 15;
               m_dp[b][d]    <= 1'b0;
               m_blink[b][d] <= 1'b0;
            end
      end else begin
         if (upd_valid && is_bnd(t)) begin
            for (int b = 0; b < NB; b++)
               for (int d = 0; d < ND; d++) begin
                  m_glyph[b][d] <= int'(glyph_in[(b*ND+d)*5 +: 5]);
                  m_dp[b][d]    <= dp_in[b*ND+d];
                  m_blink[b][d] <= blink_in[b*ND+d];
               end
         end
         t <= t + 1;
      end
   end

   int            e_pos, e_idx, e_frame;
   bit            e_phase;
   logic [ND-1:0] e_mux;
   logic [NB*7-1:0] e_seg;
   logic [NB-1:0] e_dp;
   logic          e_bnd;

   // Single compare process, away from the active edge
   always @(negedge clk_sys) begin
      if (chk_en) begin
         if (rst) begin
            chk("rst_mux",  32'(mux), 0);
            chk("rst_seg",  32'(seg), 0);
            chk("rst_dp",   32'(dp), 0);
            chk("rst_rdy",  32'(upd_ready), 0);
            chk("rst_tick", 32'(frame_tick), 0);
         end else begin
            e_pos   = t % SD;
            e_idx   = (t / SD) % ND;
            e_frame = t / FR;
            e_mux   = (e_pos >= DC) ? ND'(1 << e_idx) : '0;
            e_bnd   = is_bnd(t);
`ifdef SEG_BLINK_EN
            e_phase = ((e_frame / BD) % 2) == 0;
`else
            e_phase = 1'b1;
`endif
            for (int b = 0; b < NB; b++) begin
               if (e_mux != 0 && (e_phase || !m_blink[b][e_idx])) begin
                  e_seg[b*7 +: 7] = seg_tab[m_glyph[b][e_idx]];
                  e_dp[b]         = m_dp[b][e_idx];
               end else begin
                  e_seg[b*7 +: 7] = 7'b0;
                  e_dp[b]         = 1'b0;
               end
            end
            chk("mux",  32'(mux), 32'(e_mux));
            chk("seg",  32'(seg), 32'(e_seg));
            chk("dp",   32'(dp), 32'(e_dp));
            chk("rdy",  32'(upd_ready), 32'(e_bnd));
            chk("tick", 32'(frame_tick), 32'(e_bnd));
         end
      end
   end

   // Wait (bounded) for the negedge of model cycle `target`
   task automatic wait_t(input int target);
      int guard;
      guard = 0;
      while (t != target && guard < 5000) begin
         @(negedge clk_sys);
         guard++;
      end
      if (t != target) chk("wait_t", 32'(t), 32'(target));
   endtask

   task automatic set_glyph(input int b, input int d, input int g);
      glyph_in[(b*ND+d)*5 +: 5] = 5'(g);
   endtask

   int  base;
   bit  drop_next;

   initial begin
      for (int i = 0; i < 32; i++) seg_tab[i] = 7'b0;
      seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
      seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
      seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
      seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
      seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
      seg_tab[10] = 7'b1011011; seg_tab[11] = 7'b1001111;
      seg_tab[12] = 7'b0001110; seg_tab[13] = 7'b1001110;
      seg_tab[14] = 7'b0001111; seg_tab[16] = 7'b0000001;

      repeat (2) @(posedge clk_sys);
      chk_en = 1'b1;

      // A: offer bank0 {1,2,3,4}, bank1 {5,6,7,8} from release onwards
      for (int d = 0; d < ND; d++) begin
         set_glyph(0, d, d + 1);
         set_glyph(1, d, d + 5);
      end
      upd_valid = 1'b1;
      @(posedge clk_sys); #1 rst = 1'b0;
      $display("[TB] reset released, update offered");

      wait_t(1);  chk("a_mux_t1", 32'(mux), 32'h0);
      wait_t(2);  chk("a_mux_t2", 32'(mux), 32'h1); chk("a_seg_off", 32'(seg), 32'h0);
      wait_t(7);  chk("a_mux_t7", 32'(mux), 32'h1);
      wait_t(8);  chk("a_mux_t8", 32'(mux), 32'h0);
      wait_t(10); chk("a_mux_t10", 32'(mux), 32'h2);
      wait_t(18); chk("a_mux_t18", 32'(mux), 32'h4);
      wait_t(26); chk("a_mux_t26", 32'(mux), 32'h8);
      wait_t(30); chk("a_rdy_t30", 32'(upd_ready), 32'h0);
      wait_t(31); chk("a_rdy_t31", 32'(upd_ready), 32'h1); chk("a_tick_t31", 32'(frame_tick), 32'h1);
      wait_t(32); upd_valid = 1'b0; chk("a_tick_t32", 32'(frame_tick), 32'h0);
      wait_t(34); chk("a_d0_b0", 32'(seg[6:0]), 32'(7'b0110000));
                  chk("a_d0_b1", 32'(seg[13:7]), 32'(7'b1011011));
                  chk("a_mux_t34", 32'(mux), 32'h1);
      wait_t(42); chk("a_d1_b0", 32'(seg[6:0]), 32'(7'b1101101));
      wait_t(50); chk("a_d2_b0", 32'(seg[6:0]), 32'(7'b1111001));
      wait_t(58); chk("a_d3_b0", 32'(seg[6:0]), 32'(7'b0110011));
      $display("[TB] update accepted at frame boundary");

      // B: change glyph_in without handshake
      for (int i = 0; i < NB*ND; i++) glyph_in[i*5 +: 5] = 5'($urandom_range(0, 31));
      wait_t(66); chk("b_no_tear", 32'(seg[6:0]), 32'(7'b0110000));
      $display("[TB] unhandshaked glyph change ignored");

      // C: dash+dp on bank0 digit2, code 20 on bank0 digit3, blink bank1 digit3
      wait_t(70);
      set_glyph(0, 0, 0);  set_glyph(0, 1, 9);  set_glyph(0, 2, 16); set_glyph(0, 3, 20);
      set_glyph(1, 0, 10); set_glyph(1, 1, 11); set_glyph(1, 2, 12); set_glyph(1, 3, 14);
      dp_in    = 8'b0000_0100;
      blink_in = 8'b1000_0000;
      upd_valid = 1'b1;
      wait_t(96);  upd_valid = 1'b0;
      wait_t(114); chk("c_dash_seg", 32'(seg[6:0]), 32'(7'b0000001));
                   chk("c_dash_dp", 32'(dp[0]), 32'h1);
                   chk("c_mux_d2", 32'(mux), 32'h4);
      wait_t(122); chk("c_g20", 32'(seg[6:0]), 32'h0);
                   chk("c_mux_d3", 32'(mux), 32'h8);
`ifdef SEG_BLINK_EN
                   chk("c_blink_f3", 32'(seg[13:7]), 32'h0);
`else
                   chk("c_blink_f3", 32'(seg[13:7]), 32'(7'b0001111));
`endif
      wait_t(154); chk("c_blink_f4", 32'(seg[13:7]), 32'(7'b0001111));
      wait_t(218); chk("c_mux_f6", 32'(mux), 32'h8);
`ifdef SEG_BLINK_EN
                   chk("c_blink_f6", 32'(seg[13:7]), 32'h0);
`else
                   chk("c_blink_f6", 32'(seg[13:7]), 32'(7'b0001111));
`endif
      $display("[TB] glyph 16/20 and blink frames checked");

      // D: randomized traffic, source holds valid until it sees ready
      drop_next = 1'b0;
      for (int k = 0; k < 12 * FR; k++) begin
         @(negedge clk_sys);
         if (drop_next) begin
            upd_valid = 1'b0;
            drop_next = 1'b0;
            $display("[TB] random update accepted at t=%0d", t - 1);
         end else if (upd_valid && upd_ready) begin
            drop_next = 1'b1;
         end else if (!upd_valid) begin
            for (int i = 0; i < NB*ND; i++) begin
               glyph_in[i*5 +: 5] = 5'($urandom_range(0, 31));
               dp_in[i]           = 1'($urandom_range(0, 1));
               blink_in[i]        = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) upd_valid = 1'b1;
         end
      end
      upd_valid = 1'b0;

      // E: reset mid-frame with an update pending
      base = (t / FR + 1) * FR;
      wait_t(base);
      for (int i = 0; i < NB*ND; i++) glyph_in[i*5 +: 5] = 5'd8;
      dp_in = '1;
      upd_valid = 1'b1;
      wait_t(base + 2*SD + 4);
      chk("e_mux_pre", 32'(mux), 32'h4);
      #3 rst = 1'b1;
      #1;
      chk("e_rst_mux", 32'(mux), 32'h0);
      chk("e_rst_seg", 32'(seg), 32'h0);
      chk("e_rst_dp",  32'(dp), 32'h0);
      upd_valid = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1 rst = 1'b0;
      $display("[TB] reset applied mid-frame, update dropped");
      wait_t(1);  chk("e_mux_t1", 32'(mux), 32'h0);
      wait_t(2);  chk("e_mux_t2", 32'(mux), 32'h1);
                  chk("e_seg_lost", 32'(seg), 32'h0);
      wait_t(34); chk("e_seg_f1", 32'(seg), 32'h0);
      wait_t(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
      $fatal(1, "watchdog");
   end

endmodule
